axil_reg_bank: RTL and testbench
================================

Name: axil_reg_bank

Overview:
- AXI4-Lite slave register bank. Terminates one `axi4lite_intf` (slave modport) coming from the host interconnect.
- Exposes NUM_RW control registers (read/write) and NUM_RO status registers (read-only).
- Sits directly downstream of the host AXI-Lite master. It is the standard control/status endpoint for datapath blocks.

Parameters:
- AXI4L_ADDR_WIDTH, 32, address width of s_axil.
- AXI4L_DATA_WIDTH, 32, data width of s_axil. Only 32 is supported; any other value is an elaboration error.
- NUM_RW, 8, number of RW control registers, word indices 0..NUM_RW-1. Must be >=1.
- NUM_RO, 4, number of RO status registers, word indices NUM_RW..NUM_RW+NUM_RO-1. May be 0.

Ports:
- aclk  in  1  clock, all logic rising-edge.
- aresetn  in  1  asynchronous active-low reset.
- s_axil  interface  -  axi4lite_intf.slave (AXI4L_ADDR_WIDTH, AXI4L_DATA_WIDTH).
- ctrl_o  out  NUM_RW*32  RW register contents, reg i at [32*i+31:32*i].
- wr_pulse_o  out  NUM_RW  one-cycle strobe per RW register on accepted write.
- sts_i  in  max(NUM_RO,1)*32  RO register values, sampled live.

Behaviour:
- Reset (async assert, sync release): all ctrl_o=0, wr_pulse_o=0, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0.
- awready, wready and arready are 0 during reset and are 1 on the first cycle after release.
- A reset mid-transaction abandons that transaction; no write commits.
- Decode: idx = addr[AXI4L_ADDR_WIDTH-1:2]; addr[1:0] is ignored. awprot and arprot are ignored.
  - Valid write: idx < NUM_RW.
  - Valid read: idx < NUM_RW+NUM_RO.
- Write FSM:
  - W_IDLE: awready=1 and wready=1, each accepted independently in any order or in the same cycle.
  - Once AW is accepted, awready=0 and AW is latched. Once W is accepted, wready=0 and W is latched.
  - The edge that completes the second of the two handshakes is the commit edge (edge N). Go to W_RESP.
  - Commit, valid idx: byte k of reg idx is updated iff wstrb[k]. wr_pulse_o[idx]=1 in cycle N+1 only, even when wstrb=0. bresp=OKAY.
  - Commit, invalid idx (RO or out of range): no register change, no pulse, bresp=SLVERR (2'b10).
  - W_RESP: bvalid=1 from cycle N+1, held with bresp stable until bready. The edge with bvalid&&bready returns to W_IDLE, where awready=wready=1 the next cycle.
  - Only one write is outstanding. Back-to-back throughput is one write per 2 cycles when bready is held high.
- Read FSM:
  - R_IDLE: arready=1. The arvalid handshake at edge N latches rdata/rresp and goes to R_DATA.
  - rvalid=1 in cycle N+1.
  - Valid idx: rdata = the value visible during the handshake cycle, i.e. ctrl register or sts_i, pre-commit. rresp=OKAY.
  - Invalid idx: rdata=0, rresp=SLVERR.
  - R_DATA: arready=0. rdata and rresp are held stable until rready. The edge with rvalid&&rready returns to R_IDLE.
- Read and write paths are fully independent and may be concurrent.
  - A read accepted on the same edge as a write commit to the same register returns the old value.
  - A read accepted in any later cycle returns the new value.
- sts_i is sampled only at the AR handshake edge. Later changes do not alter an rdata already presented.
- Handshake rules:
  - Valid/ready follow AXI: bvalid and rvalid never depend combinationally on bready or rready.
  - All ready and valid outputs are registered.

Test Plan:
- Reset then AW(addr 0x04)+W(0xDEADBEEF, wstrb 0xF) in the same cycle N -> ctrl_o[63:32]=0xDEADBEEF and wr_pulse_o=8'h02 in cycle N+1; bvalid=1 in N+1, bresp=0.
- W (0x11223344, wstrb 4'b0101) two cycles before AW (addr 0x08), reg 2 preloaded 0xAAAAAAAA -> reg 2=0xAA22AA44. wready=0 while waiting for AW. Exactly one wr_pulse.
- AW to addr 0x20 (idx 8 = RO, NUM_RW=8) -> bresp=2'b10, ctrl_o unchanged, wr_pulse_o=0. AR addr 0x30 (idx 12, out of range) -> rdata=0, rresp=2'b10.
- sts_i word 1 = 0xCAFE0001, AR addr 0x24, rready held low 5 cycles while sts_i changes -> rdata stays 0xCAFE0001, rresp=0, arready=0 until the rready handshake.
- Reg 3=0x1, write 0x5 committed on the same edge as an AR to addr 0x0C -> rdata=0x1. A second AR afterwards -> 0x5.
- Assert aresetn low while bvalid=1 and the write is pending -> bvalid and rvalid drop asynchronously and ctrl_o=0. After release: awready/wready/arready=1, and a fresh write completes normally.

Source files
------------

// File: rtl/axil_reg_bank_if.sv
// AXI4-Lite bus bundle shared by the host master and the register bank slave.
interface axi4lite_intf #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_reg_bank.sv
// AXI4-Lite control/status register bank: NUM_RW byte-writable control words
// followed by NUM_RO live status words, with independent read and write paths.
module axil_reg_bank #(
  parameter int AXI4L_ADDR_WIDTH = 32,
  parameter int AXI4L_DATA_WIDTH = 32,
  parameter int NUM_RW           = 8,
  parameter int NUM_RO           = 4
) (
  input  logic                                     aclk,
  input  logic                                     aresetn,
  axi4lite_intf.slave                              s_axil,
  output logic [NUM_RW*32-1:0]                     ctrl_o,
  output logic [NUM_RW-1:0]                        wr_pulse_o,
  input  logic [((NUM_RO > 0) ? NUM_RO : 1)*32-1:0] sts_i
);

  localparam int               IW          = AXI4L_ADDR_WIDTH - 2;
  localparam logic [IW-1:0]    L_NUM_RW    = IW'(NUM_RW);
  localparam logic [IW-1:0]    L_NUM_ALL   = IW'(NUM_RW + NUM_RO);
  localparam logic [1:0]       RESP_OKAY   = 2'b00;
  localparam logic [1:0]       RESP_SLVERR = 2'b10;

  if (AXI4L_DATA_WIDTH != 32) begin : g_bad_data_width
    $error("axil_reg_bank supports only AXI4L_DATA_WIDTH = 32");
  end
  if (NUM_RW < 1) begin : g_bad_num_rw
    $error("axil_reg_bank needs NUM_RW >= 1");
  end

  typedef enum logic {W_IDLE, W_RESP} wState_t;
  typedef enum logic {R_IDLE, R_DATA} rState_t;

  wState_t                     r_wState;
  rState_t                     r_rState;
  logic [AXI4L_ADDR_WIDTH-1:0] r_awAddr;
  logic [31:0]                 r_wData;
  logic [3:0]                  r_wStrb;
  logic                        r_awHave;
  logic                        r_wHave;

  logic                        w_awHs;
  logic                        w_wHs;
  logic                        w_arHs;
  logic                        w_awHaveNext;
  logic                        w_wHaveNext;
  logic                        w_commit;
  logic [AXI4L_ADDR_WIDTH-1:0] w_cmtAddr;
  logic [31:0]                 w_cmtData;
  logic [3:0]                  w_cmtStrb;
  logic [IW-1:0]               w_cmtIdx;
  logic                        w_wrValid;
  logic [IW-1:0]               w_arIdx;
  logic                        w_rdValid;
  logic [31:0]                 w_rdMux;
  logic                        w_unused;

  assign w_awHs       = s_axil.awvalid & s_axil.awready;
  assign w_wHs        = s_axil.wvalid & s_axil.wready;
  assign w_arHs       = s_axil.arvalid & s_axil.arready;
  assign w_awHaveNext = r_awHave | w_awHs;
  assign w_wHaveNext  = r_wHave | w_wHs;
  assign w_commit     = (r_wState == W_IDLE) & w_awHaveNext & w_wHaveNext;

  // A channel still waiting for its handshake is taken straight off the bus,
  // which lets the completing edge commit without an extra latch cycle.
  assign w_cmtAddr = r_awHave ? r_awAddr : s_axil.awaddr;
  assign w_cmtData = r_wHave  ? r_wData  : s_axil.wdata;
  assign w_cmtStrb = r_wHave  ? r_wStrb  : s_axil.wstrb;
  assign w_cmtIdx  = w_cmtAddr[AXI4L_ADDR_WIDTH-1:2];
  assign w_wrValid = w_cmtIdx < L_NUM_RW;

  assign w_arIdx   = s_axil.araddr[AXI4L_ADDR_WIDTH-1:2];
  assign w_rdValid = w_arIdx < L_NUM_ALL;

  assign w_unused = ^{w_cmtAddr[1:0], s_axil.araddr[1:0], s_axil.awprot,
                      s_axil.arprot, sts_i};

  always_comb begin
    w_rdMux = '0;
    for (int i = 0; i < NUM_RW; i++) begin
      if (w_arIdx == IW'(i)) w_rdMux = ctrl_o[32*i +: 32];
    end
    for (int j = 0; j < NUM_RO; j++) begin
      if (w_arIdx == IW'(NUM_RW + j)) w_rdMux = sts_i[32*j +: 32];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wState       <= W_IDLE;
      r_awAddr       <= '0;
      r_wData        <= '0;
      r_wStrb        <= '0;
      r_awHave       <= 1'b0;
      r_wHave        <= 1'b0;
      ctrl_o         <= '0;
      wr_pulse_o     <= '0;
      s_axil.awready <= 1'b0;
      s_axil.wready  <= 1'b0;
      s_axil.bvalid  <= 1'b0;
      s_axil.bresp   <= RESP_OKAY;
    end else begin
      wr_pulse_o <= '0;
      case (r_wState)
        W_IDLE: begin
          if (w_commit) begin
            for (int i = 0; i < NUM_RW; i++) begin
              if (w_cmtIdx == IW'(i)) begin
                for (int b = 0; b < 4; b++) begin
                  if (w_cmtStrb[b]) ctrl_o[32*i + 8*b +: 8] <= w_cmtData[8*b +: 8];
                end
                wr_pulse_o[i] <= 1'b1;
              end
            end
            s_axil.bresp   <= w_wrValid ? RESP_OKAY : RESP_SLVERR;
            s_axil.bvalid  <= 1'b1;
            s_axil.awready <= 1'b0;
            s_axil.wready  <= 1'b0;
            r_awHave       <= 1'b0;
            r_wHave        <= 1'b0;
            r_wState       <= W_RESP;
          end else begin
            // Ready comes up on the first edge after reset and drops per channel once taken.
            r_awHave       <= w_awHaveNext;
            r_wHave        <= w_wHaveNext;
            s_axil.awready <= !w_awHaveNext;
            s_axil.wready  <= !w_wHaveNext;
            if (w_awHs) r_awAddr <= s_axil.awaddr;
            if (w_wHs) begin
              r_wData <= s_axil.wdata;
              r_wStrb <= s_axil.wstrb;
            end
          end
        end
        W_RESP: begin
          if (s_axil.bready) begin
            s_axil.bvalid  <= 1'b0;
            s_axil.awready <= 1'b1;
            s_axil.wready  <= 1'b1;
            r_wState       <= W_IDLE;
          end
        end
        default: r_wState <= W_IDLE;
      endcase
    end
  end

  // Read data is captured from the pre-edge register/status view, so a write
  // committing on the same edge is not yet visible.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rState       <= R_IDLE;
      s_axil.arready <= 1'b0;
      s_axil.rvalid  <= 1'b0;
      s_axil.rdata   <= '0;
      s_axil.rresp   <= RESP_OKAY;
    end else begin
      case (r_rState)
        R_IDLE: begin
          if (w_arHs) begin
            s_axil.rdata   <= w_rdValid ? w_rdMux : 32'h0;
            s_axil.rresp   <= w_rdValid ? RESP_OKAY : RESP_SLVERR;
            s_axil.rvalid  <= 1'b1;
            s_axil.arready <= 1'b0;
            r_rState       <= R_DATA;
          end else begin
            s_axil.arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axil.rready) begin
            s_axil.rvalid  <= 1'b0;
            s_axil.arready <= 1'b1;
            r_rState       <= R_IDLE;
          end
        end
        default: r_rState <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_reg_bank.sv
// Directed plus randomized bench for axil_reg_bank against a word/byte array model.
module tb_axil_reg_bank;
  localparam int NUM_RW = 8;
  localparam int NUM_RO = 4;

  logic                   aclk = 1'b0;
  logic                   aresetn;
  logic [NUM_RW*32-1:0]   ctrl_o;
  logic [NUM_RW-1:0]      wr_pulse_o;
  logic [NUM_RO*32-1:0]   sts_i;

  int errors = 0;
  int checks = 0;
  logic [31:0] modelRegs [NUM_RW];

  axi4lite_intf #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axil_reg_bank #(
    .AXI4L_ADDR_WIDTH(32),
    .AXI4L_DATA_WIDTH(32),
    .NUM_RW(NUM_RW),
    .NUM_RO(NUM_RO)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .s_axil(bus),
    .ctrl_o(ctrl_o),
    .wr_pulse_o(wr_pulse_o),
    .sts_i(sts_i)
  );

  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed=still running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeoutFail(input string tag);
    checks++;
    errors++;
    $error("[TB] FAIL %s: observed=timeout expected=handshake", tag);
  endtask

  task automatic checkRegs();
    for (int i = 0; i < NUM_RW; i++)
      checkOutput($sformatf("ctrl%0d", i), 256'(ctrl_o[32*i +: 32]), 256'(modelRegs[i]));
  endtask

  function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] data,
                                             input logic [3:0] strb);
    logic [31:0] res = old;
    for (int b = 0; b < 4; b++) if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
    return res;
  endfunction

  task automatic expectedRead(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int idx = int'(addr >> 2);
    if (idx < NUM_RW) begin
      data = modelRegs[idx]; resp = 2'b00;
    end else if (idx < NUM_RW + NUM_RO) begin
      data = sts_i[32*(idx-NUM_RW) +: 32]; resp = 2'b00;
    end else begin
      data = 32'h0; resp = 2'b10;
    end
  endtask

  // mode 0: AW and W together, 1: W two cycles ahead of AW, 2: AW two cycles ahead of W
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input int mode);
    bit awDone = 0, wDone = 0, awHs, wHs;
    int guard = 0, gap = 0, idx, delay;
    logic [NUM_RW-1:0] expPulse = '0;
    logic [1:0] expResp;
    if (mode != 1) begin bus.awaddr = addr; bus.awvalid = 1'b1; end
    if (mode != 2) begin bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1; end
    while (!(awDone && wDone) && guard < 40) begin
      awHs = bus.awvalid && bus.awready;
      wHs  = bus.wvalid && bus.wready;
      tick();
      guard++;
      if (awHs) begin bus.awvalid = 1'b0; awDone = 1; end
      if (wHs)  begin bus.wvalid = 1'b0;  wDone = 1;  end
      if ((awDone || wDone) && !(awDone && wDone)) begin
        gap++;
        checkOutput("waitNoPulse", 256'(wr_pulse_o), 256'(0));
        if (wDone)  checkOutput("wreadyHeldLow", 256'(bus.wready), 256'(0));
        if (awDone) checkOutput("awreadyHeldLow", 256'(bus.awready), 256'(0));
        if (gap == 2) begin
          if (!awDone) begin bus.awaddr = addr; bus.awvalid = 1'b1; end
          if (!wDone) begin bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1; end
        end
      end
    end
    if (!(awDone && wDone)) begin
      timeoutFail("writeHandshake");
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      return;
    end
    idx = int'(addr >> 2);
    if (idx < NUM_RW) begin
      modelRegs[idx] = mergeBytes(modelRegs[idx], data, strb);
      expPulse[idx] = 1'b1;
      expResp = 2'b00;
    end else begin
      expResp = 2'b10;
    end
    checkOutput("bvalidAfterCommit", 256'(bus.bvalid), 256'(1));
    checkOutput("bresp", 256'(bus.bresp), 256'(expResp));
    checkOutput("wrPulse", 256'(wr_pulse_o), 256'(expPulse));
    checkRegs();
    delay = $urandom_range(0, 2);
    repeat (delay) begin
      tick();
      checkOutput("bvalidHeld", 256'(bus.bvalid), 256'(1));
      checkOutput("brespHeld", 256'(bus.bresp), 256'(expResp));
      checkOutput("pulseOneCycle", 256'(wr_pulse_o), 256'(0));
    end
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    checkOutput("bvalidDropped", 256'(bus.bvalid), 256'(0));
    checkOutput("pulseCleared", 256'(wr_pulse_o), 256'(0));
    checkOutput("awreadyBack", 256'(bus.awready), 256'(1));
    checkOutput("wreadyBack", 256'(bus.wready), 256'(1));
  endtask

  task automatic applyRead(input logic [31:0] addr, input int hold, input bit wiggle);
    int guard = 0;
    logic [31:0] expData;
    logic [1:0] expResp;
    bus.araddr = addr;
    bus.arvalid = 1'b1;
    while (!bus.arready && guard < 20) begin tick(); guard++; end
    if (!bus.arready) begin
      timeoutFail("readHandshake");
      bus.arvalid = 1'b0;
      return;
    end
    expectedRead(addr, expData, expResp);
    tick();
    bus.arvalid = 1'b0;
    checkOutput("rvalid", 256'(bus.rvalid), 256'(1));
    checkOutput("rdata", 256'(bus.rdata), 256'(expData));
    checkOutput("rresp", 256'(bus.rresp), 256'(expResp));
    checkOutput("arreadyBusy", 256'(bus.arready), 256'(0));
    repeat (hold) begin
      if (wiggle) sts_i = {$urandom, $urandom, $urandom, $urandom};
      tick();
      checkOutput("rdataHeld", 256'(bus.rdata), 256'(expData));
      checkOutput("rrespHeld", 256'(bus.rresp), 256'(expResp));
      checkOutput("arreadyHeldLow", 256'(bus.arready), 256'(0));
    end
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    checkOutput("rvalidDropped", 256'(bus.rvalid), 256'(0));
    checkOutput("arreadyBack", 256'(bus.arready), 256'(1));
  endtask

  initial begin
    logic [31:0] oldVal, d, a;
    int guard;
    aresetn = 1'b0;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    sts_i = '0;
    for (int i = 0; i < NUM_RW; i++) modelRegs[i] = 32'h0;

    repeat (3) tick();
    checkOutput("rstCtrl", 256'(ctrl_o), 256'(0));
    checkOutput("rstPulse", 256'(wr_pulse_o), 256'(0));
    checkOutput("rstBvalid", 256'(bus.bvalid), 256'(0));
    checkOutput("rstRvalid", 256'(bus.rvalid), 256'(0));
    checkOutput("rstBresp", 256'(bus.bresp), 256'(0));
    checkOutput("rstRresp", 256'(bus.rresp), 256'(0));
    checkOutput("rstRdata", 256'(bus.rdata), 256'(0));
    checkOutput("rstAwready", 256'(bus.awready), 256'(0));
    checkOutput("rstWready", 256'(bus.wready), 256'(0));
    checkOutput("rstArready", 256'(bus.arready), 256'(0));
    #2 aresetn = 1'b1;
    tick();
    checkOutput("relAwready", 256'(bus.awready), 256'(1));
    checkOutput("relWready", 256'(bus.wready), 256'(1));
    checkOutput("relArready", 256'(bus.arready), 256'(1));

    $display("[TB] same-cycle AW+W write");
    applyStimulus(32'h04, 32'hDEADBEEF, 4'hF, 0);
    checkOutput("reg1Deadbeef", 256'(ctrl_o[63:32]), 256'(32'hDEADBEEF));

    $display("[TB] W before AW with partial strobe");
    applyStimulus(32'h08, 32'hAAAAAAAA, 4'hF, 0);
    applyStimulus(32'h08, 32'h11223344, 4'b0101, 1);
    checkOutput("reg2Merge", 256'(ctrl_o[95:64]), 256'(32'hAA22AA44));
    applyStimulus(32'h14, 32'h0BADF00D, 4'b0000, 2);

    $display("[TB] invalid write and read");
    applyStimulus(32'h20, 32'h12345678, 4'hF, 0);
    applyRead(32'h30, 0, 1'b0);

    $display("[TB] status read held under rready backpressure");
    sts_i[63:32] = 32'hCAFE0001;
    applyRead(32'h24, 5, 1'b1);
    checkOutput("stsCafe", 256'(bus.rdata), 256'(32'hCAFE0001));

    $display("[TB] read racing a write commit");
    applyStimulus(32'h0C, 32'h1, 4'hF, 0);
    oldVal = modelRegs[3];
    bus.awaddr = 32'h0C; bus.wdata = 32'h5; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    bus.araddr = 32'h0C; bus.arvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    modelRegs[3] = 32'h5;
    checkOutput("raceRvalid", 256'(bus.rvalid), 256'(1));
    checkOutput("raceOldData", 256'(bus.rdata), 256'(oldVal));
    checkOutput("raceBvalid", 256'(bus.bvalid), 256'(1));
    checkOutput("racePulse", 256'(wr_pulse_o), 256'(8'h08));
    bus.bready = 1'b1; bus.rready = 1'b1;
    tick();
    bus.bready = 1'b0; bus.rready = 1'b0;
    applyRead(32'h0C, 0, 1'b0);
    checkOutput("raceNewData", 256'(bus.rdata), 256'(32'h5));

    $display("[TB] randomized traffic");
    for (int n = 0; n < 40; n++) begin
      sts_i = {$urandom, $urandom, $urandom, $urandom};
      a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      d = $urandom;
      if ($urandom_range(0, 1) == 0)
        applyStimulus(a, d, 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
      else
        applyRead(a, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] reset during pending response");
    bus.awaddr = 32'h10; bus.wdata = 32'h76543210; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    bus.araddr = 32'h00; bus.arvalid = 1'b1;
    guard = 0;
    while (!(bus.awready && bus.wready && bus.arready) && guard < 10) begin tick(); guard++; end
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    checkOutput("preRstBvalid", 256'(bus.bvalid), 256'(1));
    checkOutput("preRstRvalid", 256'(bus.rvalid), 256'(1));
    #2 aresetn = 1'b0;
    #1;
    checkOutput("asyncBvalid", 256'(bus.bvalid), 256'(0));
    checkOutput("asyncRvalid", 256'(bus.rvalid), 256'(0));
    checkOutput("asyncCtrl", 256'(ctrl_o), 256'(0));
    checkOutput("asyncAwready", 256'(bus.awready), 256'(0));
    for (int i = 0; i < NUM_RW; i++) modelRegs[i] = 32'h0;
    @(posedge aclk);
    #3 aresetn = 1'b1;
    tick();
    checkOutput("rel2Awready", 256'(bus.awready), 256'(1));
    checkOutput("rel2Wready", 256'(bus.wready), 256'(1));
    checkOutput("rel2Arready", 256'(bus.arready), 256'(1));
    applyStimulus(32'h1C, 32'hA5A55A5A, 4'hF, 0);
    applyRead(32'h1C, 1, 1'b0);
    checkOutput("postRstRead", 256'(bus.rdata), 256'(32'hA5A55A5A));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
